machine_mem_responder: RTL

- Memory-side responder for the Machine action bus.
- Each cycle it accepts one 95-bit action (read, write or none) from the Machine step logic and executes it against an internal word store.
- It returns a 65-bit response on a fixed-latency pipeline; that response is the input the Machine service stage consumes on the following step.
- It also keeps saturating activity counters for debug.

---
 rtl/machine_mem_responder_pkg.sv | 38 +++
 rtl/machine_mem_responder_delay.sv | 34 +++
 rtl/machine_mem_responder.sv | 109 ++++++++++
 3 files changed

// File: rtl/machine_mem_responder_pkg.sv
// Shared encodings for the Machine action bus and memory response word.
// Used by the step, service and memory-responder blocks.
package machine_mem_types;

    localparam int unsigned ADDR_W   = 30;
    localparam int unsigned DATA_W   = 63;
    localparam int unsigned ACTION_W = 95;
    localparam int unsigned RESP_W   = 65;
    localparam int unsigned TAG_W    = 2;

    localparam int unsigned ACT_TAG_HI = 94;
    localparam int unsigned ACT_TAG_LO = 93;
    localparam int unsigned ACT_PTR_HI = 92;
    localparam int unsigned ACT_PTR_LO = 63;
    localparam int unsigned ACT_X_HI   = 62;
    localparam int unsigned ACT_X_LO   = 0;
    localparam int unsigned RSP_TAG_HI = 64;
    localparam int unsigned RSP_TAG_LO = 63;

    // Tag 2'b11 is not listed; consumers treat it exactly like ACT_NONE.
    typedef enum logic [TAG_W-1:0] {
        ACT_READ  = 2'b00,
        ACT_WRITE = 2'b01,
        ACT_NONE  = 2'b10
    } act_tag_e;

    typedef enum logic [TAG_W-1:0] {
        RSP_NONE  = 2'b00,
        RSP_READ  = 2'b01,
        RSP_WACK  = 2'b10,
        RSP_FAULT = 2'b11
    } rsp_tag_e;

    function automatic logic [31:0] sat_inc(input logic [31:0] v);
        return (v == '1) ? v : v + 32'd1;
    endfunction

endpackage

// File: rtl/machine_mem_responder_delay.sv
// Fixed-length shift register for response words with synchronous clear.
// STAGES = 0 degenerates to a wire.
module machine_mem_delay #(
    parameter int unsigned STAGES = 1,
    parameter int unsigned WIDTH  = 65
) (
    input  logic             clk,
    input  logic             clr,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    generate
        if (STAGES == 0) begin : g_bypass
            logic w_unused;
            assign w_unused = &{1'b0, clk, clr};
            assign q = d;
        end else begin : g_pipe
            logic [WIDTH-1:0] r_pipe [STAGES];

            always_ff @(posedge clk) begin
                if (clr) begin
                    for (int unsigned i = 0; i < STAGES; i++) r_pipe[i] <= '0;
                end else begin
                    r_pipe[0] <= d;
                    for (int unsigned i = 1; i < STAGES; i++) r_pipe[i] <= r_pipe[i-1];
                end
            end

            assign q = r_pipe[STAGES-1];
        end
    endgenerate

endmodule

// File: rtl/machine_mem_responder.sv
// Memory-side responder: executes one bus action per cycle against a
// single-port word store and returns a fixed-latency response.
module machine_mem_responder
    import machine_mem_types::*;
#(
    parameter int unsigned ADDR_W  = machine_mem_types::ADDR_W,
    parameter int unsigned DATA_W  = machine_mem_types::DATA_W,
    parameter int unsigned DEPTH   = 1024,
    parameter int unsigned LATENCY = 2
) (
    input  logic                system1000,
    input  logic                system1000_rst,
    input  logic [ACTION_W-1:0] action,
    output logic [RESP_W-1:0]   resp,
    output logic [31:0]         rd_count,
    output logic [31:0]         wr_count,
    output logic [31:0]         fault_count
);

    localparam int unsigned IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [TAG_W-1:0]  w_tag;
    logic [ADDR_W-1:0] w_ptr;
    logic [DATA_W-1:0] w_x;
    logic [IDX_W-1:0]  w_idx;
    logic              w_in_range;
    logic              w_is_read;
    logic              w_is_write;
    logic [RESP_W-1:0] w_rsp_nodata;
    logic [RESP_W-1:0] w_s1_rsp;

    logic [DATA_W-1:0] r_mem [DEPTH];
    logic [DATA_W-1:0] r_rdata;
    logic              r_s1_sel_rd;
    logic [RESP_W-1:0] r_s1_rsp;
    logic [31:0]       r_rd_count;
    logic [31:0]       r_wr_count;
    logic [31:0]       r_fault_count;

    assign w_tag      = action[ACT_TAG_HI:ACT_TAG_LO];
    assign w_ptr      = action[ACT_PTR_HI:ACT_PTR_LO];
    assign w_x        = action[ACT_X_HI:ACT_X_LO];
    assign w_idx      = w_ptr[IDX_W-1:0];
    assign w_in_range = 32'(w_ptr) < 32'(DEPTH);
    assign w_is_read  = (w_tag == ACT_READ);
    assign w_is_write = (w_tag == ACT_WRITE);

    // Everything except in-range read data is known at accept time.
    always_comb begin
        w_rsp_nodata = '0;
        if (w_is_read || w_is_write) begin
            if (!w_in_range)
                w_rsp_nodata = {RSP_FAULT, {(DATA_W-ADDR_W){1'b0}}, w_ptr};
            else if (w_is_write)
                w_rsp_nodata = {RSP_WACK, w_x};
        end
    end

    always_ff @(posedge system1000) begin
        if (!system1000_rst && w_in_range) begin
            if (w_is_write)
                r_mem[w_idx] <= w_x;
            else if (w_is_read)
                r_rdata <= r_mem[w_idx];
        end
    end

    always_ff @(posedge system1000) begin
        if (system1000_rst) begin
            r_s1_sel_rd <= 1'b0;
            r_s1_rsp    <= '0;
        end else begin
            r_s1_sel_rd <= w_is_read && w_in_range;
            r_s1_rsp    <= w_rsp_nodata;
        end
    end

    assign w_s1_rsp = r_s1_sel_rd ? {RSP_READ, r_rdata} : r_s1_rsp;

    machine_mem_delay #(
        .STAGES (LATENCY - 1),
        .WIDTH  (RESP_W)
    ) u_delay (
        .clk (system1000),
        .clr (system1000_rst),
        .d   (w_s1_rsp),
        .q   (resp)
    );

    always_ff @(posedge system1000) begin
        if (system1000_rst) begin
            r_rd_count    <= '0;
            r_wr_count    <= '0;
            r_fault_count <= '0;
        end else if (w_is_read || w_is_write) begin
            if (!w_in_range)
                r_fault_count <= sat_inc(r_fault_count);
            else if (w_is_read)
                r_rd_count <= sat_inc(r_rd_count);
            else
                r_wr_count <= sat_inc(r_wr_count);
        end
    end

    assign rd_count    = r_rd_count;
    assign wr_count    = r_wr_count;
    assign fault_count = r_fault_count;

endmodule
